instr_encoder: RTL and testbench

- Inverse of the R-type funct decoder. Takes symbolic operation requests (addu/subu/jr plus register fields) and builds 32-bit MIPS R-type instruction words.
- Buffers encoded words in a small FIFO and streams them to an instruction-memory write port with sequential word addresses.
- Used as a self-loading stimulus and boot path that fills IM before the P4 CPU runs.

---
 rtl/instr_encoder_pkg.sv | 39 +++
 rtl/instr_encoder_sync_fifo.sv | 75 +++++++
 rtl/instr_encoder.sv | 90 +++++++++
 tb/tb_instr_encoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared MIPS R-type encoding constants and the request-to-word encoder.
package instr_encoder_pkg;

    // R-type opcode and funct values, shared with the funct decoder.
    localparam logic [5:0] R_OP       = 6'b000000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    // Instruction memory is byte addressed; one word per step.
    localparam logic [31:0] WORD_STEP = 32'd4;

    // Symbolic request operation codes.
    typedef enum logic [1:0] {
        OP_ADDU    = 2'd0,
        OP_SUBU    = 2'd1,
        OP_JR      = 2'd2,
        OP_ILLEGAL = 2'd3
    } req_op_e;

    // Build the final 32-bit word; jr drops rt/rd entirely.
    function automatic logic [31:0] encode_instr(
        input req_op_e    op,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        logic [31:0] word;
        word = '0;
        case (op)
            OP_ADDU: word = {R_OP, rs, rt, rd, 5'b00000, FUNCT_ADDU};
            OP_SUBU: word = {R_OP, rs, rt, rd, 5'b00000, FUNCT_SUBU};
            OP_JR:   word = {R_OP, rs, 15'b0, FUNCT_JR};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO with occupancy-based full/empty and free-running pointers.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (fill_q == (AW+1)'(DEPTH));
    assign empty = (fill_q == '0);
    assign fill  = fill_q;
    assign rdata = mem[rd_ptr_q];

    // Next-state for pointers and occupancy; clear wins over push and pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   fill_d = fill_q + (AW+1)'(1);
                2'b01:   fill_d = fill_q - (AW+1)'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; fill gates every read so stale data is never visible.
        if (push_ok && !clear) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes addu/subu/jr requests into R-type words and streams them to IM.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_op,
    input  logic [4:0]                  req_rs,
    input  logic [4:0]                  req_rt,
    input  logic [4:0]                  req_rd,
    output logic                        im_valid,
    input  logic                        im_ready,
    output logic [31:0]                 im_addr,
    output logic [31:0]                 im_data,
    output logic [$clog2(DEPTH):0]      fill,
    output logic [7:0]                  err_cnt
);

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        req_accept;
    logic        op_illegal;
    logic [31:0] enc_word;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Handshakes and encoding; req_ready never looks at im_ready.
    always_comb begin
        req_ready  = !fifo_full && !clear;
        req_accept = req_valid && req_ready;
        op_illegal = (req_op_e'(req_op) == OP_ILLEGAL);
        fifo_push  = req_accept && !op_illegal;
        fifo_pop   = !fifo_empty && im_ready && !clear;
        enc_word   = encode_instr(req_op_e'(req_op), req_rs, req_rt, req_rd);
    end

    // Address counter and saturating illegal-request counter next state.
    always_comb begin
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        if (clear) begin
            addr_d    = BASE_ADDR;
            err_cnt_d = '0;
        end else begin
            if (fifo_pop) addr_d = addr_q + WORD_STEP;
            if (req_accept && op_illegal && (err_cnt_q != 8'hFF))
                err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else begin
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (enc_word),
        .rdata (im_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill)
    );

    assign im_valid = !fifo_empty;
    assign im_addr  = addr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: table-driven vectors plus a cycle scoreboard.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] BASE    = 32'h0000_3000;
    localparam logic [31:0] BASE_HI = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
    logic        im_ready = 1'b0;
    logic        req_ready, im_valid;
    logic [31:0] im_addr, im_data;
    logic [2:0]  fill;
    logic [7:0]  err_cnt;
    logic        hi_req_ready, hi_im_valid;
    logic [31:0] hi_im_addr, hi_im_data;
    logic [2:0]  hi_fill;
    logic [7:0]  hi_err_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] cur_exp = '0;
    logic [31:0] mq[$];
    logic [31:0] m_addr = BASE;
    logic [31:0] m_addr_hi = BASE_HI;
    logic [7:0]  m_err = '0;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .im_valid(im_valid), .im_ready(im_ready), .im_addr(im_addr),
        .im_data(im_data), .fill(fill), .err_cnt(err_cnt)
    );

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_HI)) dut_hi (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(hi_req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .im_valid(hi_im_valid), .im_ready(im_ready), .im_addr(hi_im_addr),
        .im_data(hi_im_data), .fill(hi_fill), .err_cnt(hi_err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: compare outputs against the model, then advance the model
    // with the inputs that the coming rising edge will see.
    always @(negedge clk) begin
        logic full_before;
        if (!reset) begin
            mq.delete();
            m_addr    = BASE;
            m_addr_hi = BASE_HI;
            m_err     = '0;
        end else begin
            full_before = (mq.size() == DEPTH);
            check("req_ready", {31'b0, req_ready}, {31'b0, !full_before && !clear});
            check("im_valid", {31'b0, im_valid}, {31'b0, mq.size() != 0});
            check("fill", {29'b0, fill}, mq.size());
            check("err_cnt", {24'b0, err_cnt}, {24'b0, m_err});
            check("hi_fill", {29'b0, hi_fill}, mq.size());
            if (clear) begin
                mq.delete();
                m_addr    = BASE;
                m_addr_hi = BASE_HI;
                m_err     = '0;
            end else begin
                if (mq.size() != 0 && im_ready) begin
                    check("im_data", im_data, mq[0]);
                    check("im_addr", im_addr, m_addr);
                    check("hi_im_data", hi_im_data, mq[0]);
                    check("hi_im_addr", hi_im_addr, m_addr_hi);
                    void'(mq.pop_front());
                    m_addr    = m_addr + 32'd4;
                    m_addr_hi = m_addr_hi + 32'd4;
                end
                if (req_valid && !full_before) begin
                    if (req_op != 2'd3) mq.push_back(cur_exp);
                    else if (m_err != 8'hFF) m_err = m_err + 8'd1;
                end
            end
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] exp);
        req_valid = 1'b1;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
        cur_exp = exp;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic send_vec(input vec_t v);
        send(v.op, v.rs, v.rt, v.rd, v.exp);
    endtask

    task automatic drain();
        im_ready = 1'b1;
        for (int n = 0; n < 50 && mq.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        if (mq.size() != 0) check("drain_timeout", 32'd0, 32'd1);
        im_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        req_valid = 1'b0; im_ready = 1'b0; clear = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'd0, 5'd1,  5'd2,  5'd3,  32'h0022_1821};
        vecs[1] = '{2'd1, 5'd4,  5'd5,  5'd6,  32'h0085_3023};
        vecs[2] = '{2'd2, 5'd31, 5'd7,  5'd9,  32'h03E0_0008};
        vecs[3] = '{2'd0, 5'd31, 5'd31, 5'd31, 32'h03FF_F821};
        vecs[4] = '{2'd1, 5'd0,  5'd0,  5'd0,  32'h0000_0023};
        vecs[5] = '{2'd2, 5'd0,  5'd31, 5'd31, 32'h0000_0008};
        vecs[6] = '{2'd0, 5'd10, 5'd20, 5'd30, 32'h0154_F021};
        vecs[7] = '{2'd1, 5'd17, 5'd8,  5'd25, 32'h0228_C823};

        // Reset state.
        #12 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_im_valid", {31'b0, im_valid}, 32'd0);
        check("rst_fill", {29'b0, fill}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_addr", im_addr, BASE);

        // First word: one-cycle latency, no bypass.
        im_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3;
        cur_exp = 32'h0022_1821;
        @(negedge clk);
        check("lat_no_bypass", {31'b0, im_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("lat_valid", {31'b0, im_valid}, 32'd1);
        check("lat_data", im_data, 32'h0022_1821);
        check("lat_addr", im_addr, 32'h0000_3000);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_valid_drop", {31'b0, im_valid}, 32'd0);
        @(posedge clk); #1;

        // subu then jr from a fresh reset, then the whole vector table.
        pulse_reset();
        im_ready = 1'b1;
        send_vec(vecs[1]);
        send_vec(vecs[2]);
        drain();
        for (int i = 0; i < 8; i++) begin
            im_ready = i[0];
            send_vec(vecs[i]);
        end
        drain();

        // Backpressure: four fill the FIFO, the fifth waits for one pop.
        pulse_reset();
        for (int i = 0; i < 4; i++) send_vec(vecs[i]);
        req_valid = 1'b1; req_op = vecs[4].op; req_rs = vecs[4].rs;
        req_rt = vecs[4].rt; req_rd = vecs[4].rd; cur_exp = vecs[4].exp;
        @(negedge clk);
        check("full_fill", {29'b0, fill}, 32'd4);
        check("full_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        im_ready = 1'b1;
        @(negedge clk);
        check("full_pop_ready", {31'b0, req_ready}, 32'd0);
        check("full_pop_addr", im_addr, 32'h0000_3000);
        @(posedge clk); #1;
        im_ready = 1'b0;
        @(negedge clk);
        check("after_pop_fill", {29'b0, fill}, 32'd3);
        check("after_pop_ready", {31'b0, req_ready}, 32'd1);
        check("after_pop_addr", im_addr, 32'h0000_3004);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("refill", {29'b0, fill}, 32'd4);
        @(posedge clk); #1;
        drain();

        // Illegal requests interleaved with legal ones, then saturation.
        pulse_reset();
        send_vec(vecs[0]);
        send(2'd3, 5'd1, 5'd1, 5'd1, 32'd0);
        send_vec(vecs[1]);
        send(2'd3, 5'd2, 5'd2, 5'd2, 32'd0);
        send(2'd3, 5'd3, 5'd3, 5'd3, 32'd0);
        send_vec(vecs[2]);
        @(negedge clk);
        check("err_three", {24'b0, err_cnt}, 32'd3);
        @(posedge clk); #1;
        drain();
        for (int i = 0; i < 256; i++) send(2'd3, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        check("err_sat", {24'b0, err_cnt}, 32'h0000_00FF);
        @(posedge clk); #1;

        // Clear with three queued words and a live sink handshake.
        send_vec(vecs[3]);
        send_vec(vecs[4]);
        send_vec(vecs[5]);
        clear = 1'b1; im_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'd0; cur_exp = 32'hDEAD_BEEF;
        @(negedge clk);
        check("clear_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; im_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("clear_fill", {29'b0, fill}, 32'd0);
        check("clear_valid", {31'b0, im_valid}, 32'd0);
        check("clear_err", {24'b0, err_cnt}, 32'd0);
        check("clear_addr", im_addr, 32'h0000_3000);
        @(posedge clk); #1;
        send_vec(vecs[6]);
        drain();

        // Asynchronous reset mid-stream, then the wrapping high-base instance.
        send_vec(vecs[0]);
        send_vec(vecs[1]);
        #2 reset = 1'b0;
        #1;
        check("async_valid", {31'b0, im_valid}, 32'd0);
        check("async_fill", {29'b0, fill}, 32'd0);
        @(negedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        send_vec(vecs[6]);
        send_vec(vecs[7]);
        @(negedge clk);
        check("post_rst_addr", im_addr, 32'h0000_3000);
        check("hi_addr0", hi_im_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        im_ready = 1'b1;
        @(posedge clk); #1;
        im_ready = 1'b0;
        @(negedge clk);
        check("hi_addr_wrap", hi_im_addr, 32'h0000_0000);
        check("post_rst_addr1", im_addr, 32'h0000_3004);
        check("hi_data1", hi_im_data, 32'h0228_C823);
        @(posedge clk); #1;
        drain();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
